// File: rtl/bsk_prd_pkg.sv
// ---------------------------------------------------------------------------
// bsk_prd_pkg
// Shared definitions for the PRD command-receiver board controller:
//   - backplane register addresses
//   - ctrl register bit positions
//   - helpers that build the ID word and one status byte
// ---------------------------------------------------------------------------
package bsk_prd_pkg;

    localparam logic [3:0] ADDR_STAT0  = 4'd0;
    localparam logic [3:0] ADDR_STAT1  = 4'd1;
    localparam logic [3:0] ADDR_STAT2  = 4'd2;
    localparam logic [3:0] ADDR_STAT3  = 4'd3;
    localparam logic [3:0] ADDR_IND_LO = 4'd4;
    localparam logic [3:0] ADDR_IND_HI = 4'd5;
    localparam logic [3:0] ADDR_EVT_LO = 4'd6;
    localparam logic [3:0] ADDR_EVT_HI = 4'd7;
    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_ID     = 4'd9;

    localparam int CTRL_TEST_EN = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_DIV_LSB = 8;

    // Status pattern returned while the board is in test mode.
    localparam logic [15:0] STAT_TEST_WORD = 16'hF0F0;

    function automatic logic [15:0] id_word(input logic [7:0] password,
                                            input logic [6:0] version,
                                            input logic       test_en);
        return {password, version, test_en};
    endfunction

    // One nibble group of filtered inputs, inverted copy in the high half.
    function automatic logic [7:0] stat_byte(input logic [3:0] filt);
        return {~filt, filt};
    endfunction

endpackage

// File: rtl/bsk_cmd_filter.sv
// ---------------------------------------------------------------------------
// bsk_cmd_filter
// Single-channel debouncer: 2-flop synchroniser, run-length counter and the
// accepted (filtered) level. A new level is accepted only after FILT_LEN
// consecutive samples that differ from the current filtered level.
// Ports:
//   clk, aclr   - clock, asynchronous active-high reset
//   i_com       - raw command input
//   o_filt      - filtered level (registered)
//   o_toggle    - high in the cycle whose clock edge toggles o_filt
// ---------------------------------------------------------------------------
module bsk_cmd_filter #(
    parameter int FILT_LEN = 8,
    parameter int FILT_W   = $clog2(FILT_LEN + 1)
) (
    input  logic clk,
    input  logic aclr,
    input  logic i_com,
    output logic o_filt,
    output logic o_toggle
);

    logic              sync1_q;
    logic              sync2_q;
    logic              filt_q;
    logic              filt_d;
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;
    logic              hit;

    // The FILT_LEN-th differing sample toggles the level on this edge.
    assign hit = (sync2_q != filt_q) && (cnt_q == FILT_W'(FILT_LEN - 1));

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (hit) begin
            cnt_d  = '0;
            filt_d = ~filt_q;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_com;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_filt   = filt_q;
    assign o_toggle = hit;

endmodule

// File: rtl/bsk_prd_rx.sv
// ---------------------------------------------------------------------------
// bsk_prd_rx
// Command-receiver board controller: debounces CH_NUM command inputs,
// latches per-channel change events (W1C) with a maskable interrupt,
// exposes status/indication/event/ctrl/ID registers on the backplane bus
// and generates a programmable test frequency.
// Ports:
//   clk, aclr         - clock, asynchronous active-high reset
//   i_cs, i_a         - chip-select code and register address (raw)
//   i_rd_n, i_wr_n    - read / write strobes, active low
//   i_bl_n            - blocks the test output, active low
//   i_wdata, o_rdata  - bus write / read data
//   o_rdata_oe        - enable for the top-level bidirectional data driver
//   i_com             - raw command inputs
//   o_com_ind_n       - indication LEDs, active low
//   o_cs_n            - board selected, active low
//   o_test, o_irq     - test frequency output, interrupt request
//
// Bus protocol: reads are asynchronous -- o_rdata follows i_a combinationally
// and is driven onto the bus while cs & ~i_rd_n. A write commits once, on the
// synchronised rising edge of i_wr_n while i_cs matches; i_a, i_wdata and
// i_cs are taken raw at that moment and must be held stable from at least
// 3 clk before i_wr_n rises until the commit (3 clk after the rise).
// ---------------------------------------------------------------------------
module bsk_prd_rx #(
    parameter int         CH_NUM       = 16,
    parameter int         FILT_LEN     = 8,
    parameter int         FILT_W       = $clog2(FILT_LEN + 1),
    parameter logic [6:0] VERSION      = 7'h26,
    parameter logic [7:0] PASSWORD     = 8'hA4,
    parameter logic [3:0] CS_ADDR      = 4'b1011,
    parameter logic [7:0] TEST_DIV_DEF = 8'd4
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic [3:0]        i_cs,
    input  logic [3:0]        i_a,
    input  logic              i_rd_n,
    input  logic              i_wr_n,
    input  logic              i_bl_n,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata,
    output logic              o_rdata_oe,
    input  logic [CH_NUM-1:0] i_com,
    output logic [CH_NUM-1:0] o_com_ind_n,
    output logic              o_cs_n,
    output logic              o_test,
    output logic              o_irq
);

    import bsk_prd_pkg::*;

    localparam int NWORDS = CH_NUM / 8;

    logic [CH_NUM-1:0] filt;
    logic [CH_NUM-1:0] tog;

    logic              wr_s1_q, wr_s2_q, wr_s3_q;
    logic              bl_s1_q, bl_s2_q;
    logic              cs;
    logic              commit;

    logic [CH_NUM-1:0] com_ind_q, com_ind_d;
    logic [CH_NUM-1:0] ev_q, ev_d;
    logic [CH_NUM-1:0] ev_clr;
    logic              test_en_q, test_en_d;
    logic              irq_en_q, irq_en_d;
    logic [7:0]        test_div_q, test_div_d;
    logic [7:0]        test_cnt_q, test_cnt_d;
    logic              test_clk_q, test_clk_d;
    logic              test_q;
    logic              irq_q;
    logic [7:0]        div_eff;

    logic [31:0]       filt_ext;
    logic [31:0]       com_ind_ext;
    logic [31:0]       ev_ext;
    logic [4:0]        stat_base;
    logic [15:0]       rdata;

    // ------------------------------------------------------------ filters
    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        bsk_cmd_filter #(
            .FILT_LEN (FILT_LEN),
            .FILT_W   (FILT_W)
        ) u_filt (
            .clk      (clk),
            .aclr     (aclr),
            .i_com    (i_com[g]),
            .o_filt   (filt[g]),
            .o_toggle (tog[g])
        );
    end

    // ------------------------------------------------------- write decode
    assign cs     = (i_cs == CS_ADDR);
    // Synced wr_n 0->1 edge; wr_s3_q only serves edge detection.
    assign commit = cs & wr_s2_q & ~wr_s3_q;

    always_comb begin
        com_ind_d  = com_ind_q;
        ev_clr     = '0;
        test_en_d  = test_en_q;
        irq_en_d   = irq_en_q;
        test_div_d = test_div_q;

        // Channels 0..15 live in the low word, 16..31 in the high word.
        for (int i = 0; i < CH_NUM; i++) begin
            if (commit && (i_a == ((i < 16) ? ADDR_IND_LO : ADDR_IND_HI))) begin
                com_ind_d[i] = i_wdata[i % 16];
            end
            if (commit && (i_a == ((i < 16) ? ADDR_EVT_LO : ADDR_EVT_HI))) begin
                ev_clr[i] = i_wdata[i % 16];
            end
        end

        if (commit && (i_a == ADDR_CTRL)) begin
            test_en_d  = i_wdata[CTRL_TEST_EN];
            irq_en_d   = i_wdata[CTRL_IRQ_EN];
            test_div_d = i_wdata[CTRL_DIV_LSB +: 8];
        end
    end

    // A toggle in the same cycle as a W1C clear keeps the event.
    assign ev_d = (ev_q & ~ev_clr) | tog;

    // ------------------------------------------------------ test generator
    assign div_eff = (test_div_q == 8'd0) ? 8'd1 : test_div_q;

    always_comb begin
        test_cnt_d = test_cnt_q - 8'd1;
        test_clk_d = test_clk_q;
        if (test_cnt_q == 8'd0) begin
            test_cnt_d = div_eff - 8'd1;
            test_clk_d = ~test_clk_q;
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_s1_q    <= 1'b1;
            wr_s2_q    <= 1'b1;
            wr_s3_q    <= 1'b1;
            bl_s1_q    <= 1'b1;
            bl_s2_q    <= 1'b1;
            com_ind_q  <= '0;
            ev_q       <= '0;
            test_en_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            test_div_q <= TEST_DIV_DEF;
            test_cnt_q <= 8'd0;
            test_clk_q <= 1'b0;
            test_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_s1_q    <= i_wr_n;
            wr_s2_q    <= wr_s1_q;
            wr_s3_q    <= wr_s2_q;
            bl_s1_q    <= i_bl_n;
            bl_s2_q    <= bl_s1_q;
            com_ind_q  <= com_ind_d;
            ev_q       <= ev_d;
            test_en_q  <= test_en_d;
            irq_en_q   <= irq_en_d;
            test_div_q <= test_div_d;
            test_cnt_q <= test_cnt_d;
            test_clk_q <= test_clk_d;
            test_q     <= test_clk_q & test_en_q & bl_s2_q;
            irq_q      <= irq_en_q & (|ev_q);
        end
    end

    // ----------------------------------------------------------- read path
    assign filt_ext    = 32'(filt);
    assign com_ind_ext = 32'(com_ind_q);
    assign ev_ext      = 32'(ev_q);
    assign stat_base   = {i_a[1:0], 3'b000};

    always_comb begin
        rdata = '0;
        case (i_a)
            ADDR_STAT0, ADDR_STAT1, ADDR_STAT2, ADDR_STAT3: begin
                if (32'(i_a[1:0]) < 32'(NWORDS)) begin
                    if (test_en_q) begin
                        rdata = STAT_TEST_WORD;
                    end else begin
                        rdata = {stat_byte(filt_ext[stat_base + 5'd4 +: 4]),
                                 stat_byte(filt_ext[stat_base +: 4])};
                    end
                end
            end
            ADDR_IND_LO: rdata = com_ind_ext[15:0];
            ADDR_IND_HI: rdata = com_ind_ext[31:16];
            ADDR_EVT_LO: rdata = ev_ext[15:0];
            ADDR_EVT_HI: rdata = ev_ext[31:16];
            ADDR_CTRL:   rdata = {test_div_q, 6'b000000, irq_en_q, test_en_q};
            ADDR_ID:     rdata = id_word(PASSWORD, VERSION, test_en_q);
            default:     rdata = '0;
        endcase
    end

    assign o_rdata     = rdata;
    assign o_rdata_oe  = cs & ~i_rd_n;
    assign o_cs_n      = ~cs;
    assign o_com_ind_n = ~com_ind_q;
    assign o_test      = test_q;
    assign o_irq       = irq_q;

endmodule
